// File: rtl/pipeline_defs.sv
// Shared pipeline definitions: datapath widths and load-type encodings used by
// the MEM/WB stage and any later load-handling units.
package pipeline_defs;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  // Encodings 3'b101..3'b111 are not listed; consumers treat them as a word load.
  typedef enum logic [2:0] {
    LT_LW  = 3'b000,
    LT_LB  = 3'b001,
    LT_LBU = 3'b010,
    LT_LH  = 3'b011,
    LT_LHU = 3'b100
  } load_type_e;

endpackage

// File: rtl/load_extender.sv
// Combinational big-endian load alignment and sign/zero extension.
// Byte 0 is the most significant byte; halfword offset[0] is ignored.
module load_extender
  import pipeline_defs::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        offset,
  input  logic [2:0]        load_type,
  output logic [DATA_W-1:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (offset)
      2'd0: byte_sel = mem_rdata[31:24];
      2'd1: byte_sel = mem_rdata[23:16];
      2'd2: byte_sel = mem_rdata[15:8];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = offset[1] ? mem_rdata[15:0] : mem_rdata[31:16];
  end

  always_comb begin
    ext_data = mem_rdata;
    case (load_type)
      LT_LB:   ext_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LT_LBU:  ext_data = {{(DATA_W-8){1'b0}}, byte_sel};
      LT_LH:   ext_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LT_LHU:  ext_data = {{(DATA_W-16){1'b0}}, half_sel};
      default: ext_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB latch and register-bank write driver, with a one-cycle hold of the
// last committed write for ID bypass and a retired-instruction counter.
module writeback_stage
  import pipeline_defs::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic              reg_write_in,
  input  logic              mem_to_reg,
  input  logic [REG_AW-1:0] rd_in,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [2:0]        load_type,
  output logic [REG_AW-1:0] write_register,
  output logic [DATA_W-1:0] write_data,
  output logic              Reg_write,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic [31:0]       retired
);

  // valid_in qualifies the MEM-stage payload; there is no backpressure to MEM,
  // stall/flush decide per edge whether that payload is taken, held or dropped.
  logic [DATA_W-1:0] ext_data;

  logic              reg_write_q, reg_write_d;
  logic [REG_AW-1:0] wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              fwd_valid_q;
  logic [REG_AW-1:0] fwd_reg_q;
  logic [DATA_W-1:0] fwd_data_q;
  logic [31:0]       retired_q, retired_d;
  logic              accept;

  load_extender #(.DATA_W(DATA_W)) u_load_extender (
    .mem_rdata (mem_rdata),
    .offset    (alu_result[1:0]),
    .load_type (load_type),
    .ext_data  (ext_data)
  );

  assign accept = valid_in & ~flush & ~stall;

  always_comb begin
    reg_write_d = 1'b0;
    wr_reg_d    = wr_reg_q;
    wr_data_d   = wr_data_q;
    retired_d   = retired_q;
    // Held cycles never re-pulse, so one instruction yields one bank write.
    if (!flush && !stall) begin
      reg_write_d = valid_in & reg_write_in & (rd_in != '0);
      wr_reg_d    = rd_in;
      wr_data_d   = mem_to_reg ? ext_data : alu_result;
    end
    if (accept) begin
      retired_d = retired_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_q <= 1'b0;
      wr_reg_q    <= '0;
      wr_data_q   <= '0;
      fwd_valid_q <= 1'b0;
      fwd_reg_q   <= '0;
      fwd_data_q  <= '0;
      retired_q   <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      wr_reg_q    <= wr_reg_d;
      wr_data_q   <= wr_data_d;
      fwd_valid_q <= reg_write_q;
      fwd_reg_q   <= wr_reg_q;
      fwd_data_q  <= wr_data_q;
      retired_q   <= retired_d;
    end
  end

  assign write_register = wr_reg_q;
  assign write_data     = wr_data_q;
  assign Reg_write      = reg_write_q;
  assign fwd_valid      = fwd_valid_q;
  assign fwd_reg        = fwd_reg_q;
  assign fwd_data       = fwd_data_q;
  assign retired        = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed and randomized bench for writeback_stage against a behavioural
// model of the MEM/WB register, bypass hold and retire counter.
module tb_writeback_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        valid_in;
  logic        reg_write_in;
  logic        mem_to_reg;
  logic [4:0]  rd_in;
  logic [31:0] alu_result;
  logic [31:0] mem_rdata;
  logic [2:0]  load_type;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic        Reg_write;
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
  logic [31:0] retired;

  writeback_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .valid_in       (valid_in),
    .reg_write_in   (reg_write_in),
    .mem_to_reg     (mem_to_reg),
    .rd_in          (rd_in),
    .alu_result     (alu_result),
    .mem_rdata      (mem_rdata),
    .load_type      (load_type),
    .write_register (write_register),
    .write_data     (write_data),
    .Reg_write      (Reg_write),
    .fwd_valid      (fwd_valid),
    .fwd_reg        (fwd_reg),
    .fwd_data       (fwd_data),
    .retired        (retired)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model and scoreboard ----------------
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];

  logic        m_rw;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  logic        m_fv;
  logic [4:0]  m_freg;
  logic [31:0] m_fdata;
  logic [31:0] m_ret;

  function automatic logic [31:0] ref_load(input logic [31:0] mem,
                                           input int off, input int lt);
    logic [31:0] v;
    if (lt == 1 || lt == 2) begin
      v = (mem >> (8 * (3 - off))) & 32'h0000_00FF;
      if (lt == 1 && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (lt == 3 || lt == 4) begin
      v = (mem >> ((off >= 2) ? 0 : 16)) & 32'h0000_FFFF;
      if (lt == 3 && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else begin
      v = mem;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_rw = 0; m_reg = 0; m_data = 0;
    m_fv = 0; m_freg = 0; m_fdata = 0;
    m_ret = 0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    m_fv = m_rw; m_freg = m_reg; m_fdata = m_data;
    if (flush) begin
      m_rw = 0;
    end else if (!stall) begin
      m_rw   = valid_in && reg_write_in && (rd_in != 0);
      m_reg  = rd_in;
      m_data = mem_to_reg ? ref_load(mem_rdata, int'(alu_result[1:0]), int'(load_type))
                          : alu_result;
      if (valid_in) m_ret = m_ret + 1;
    end else begin
      m_rw = 0;
    end
    if (m_rw) exp_q.push_back(m_data);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [31:0] e;
    check("reg_write", {31'd0, Reg_write}, {31'd0, m_rw});
    check("write_register", {27'd0, write_register}, {27'd0, m_reg});
    check("write_data", write_data, m_data);
    check("fwd_valid", {31'd0, fwd_valid}, {31'd0, m_fv});
    check("fwd_reg", {27'd0, fwd_reg}, {27'd0, m_freg});
    check("fwd_data", fwd_data, m_fdata);
    check("retired", retired, m_ret);
    if (Reg_write === 1'b1) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : ~write_data;
      check("sb_write", write_data, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic rw, input logic m2r,
                       input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [2:0] lt,
                       input logic st, input logic fl);
    valid_in = v; reg_write_in = rw; mem_to_reg = m2r; rd_in = rd;
    alu_result = alu; mem_rdata = mem; load_type = lt; stall = st; flush = fl;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] lt_exp[7];
  logic [2:0]  lt_sel[7];
  logic [1:0]  lt_off[7];
  logic [31:0] ret_hold;
  int          pulses;

  initial begin
    lt_sel[0] = 3'd1; lt_off[0] = 2'd0; lt_exp[0] = 32'hFFFF_FF80;
    lt_sel[1] = 3'd2; lt_off[1] = 2'd1; lt_exp[1] = 32'h0000_00FF;
    lt_sel[2] = 3'd1; lt_off[2] = 2'd2; lt_exp[2] = 32'h0000_007F;
    lt_sel[3] = 3'd3; lt_off[3] = 2'd2; lt_exp[3] = 32'h0000_7F01;
    lt_sel[4] = 3'd3; lt_off[4] = 2'd0; lt_exp[4] = 32'hFFFF_80FF;
    lt_sel[5] = 3'd4; lt_off[5] = 2'd0; lt_exp[5] = 32'h0000_80FF;
    lt_sel[6] = 3'd0; lt_off[6] = 2'd3; lt_exp[6] = 32'h80FF_7F01;

    // Reset state
    rst = 1'b1;
    drive(0, 0, 0, 5'd0, 32'd0, 32'd0, 3'd0, 0, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b0;

    // Basic write then bypass
    drive(1, 1, 0, 5'd5, 32'h1234_5678, 32'd0, 3'd0, 0, 0);
    cycle();
    check("basic_rw", {31'd0, Reg_write}, 32'd1);
    check("basic_reg", {27'd0, write_register}, 32'd5);
    check("basic_data", write_data, 32'h1234_5678);
    drive(0, 0, 0, 5'd0, 32'd0, 32'd0, 3'd0, 0, 0);
    cycle();
    check("basic_fwd_valid", {31'd0, fwd_valid}, 32'd1);
    check("basic_fwd_reg", {27'd0, fwd_reg}, 32'd5);

    // Load extension table
    for (int i = 0; i < 7; i++) begin
      drive(1, 1, 1, 5'd10, {30'd0, lt_off[i]}, 32'h80FF_7F01, lt_sel[i], 0, 0);
      cycle();
      check($sformatf("load_ext_%0d", i), write_data, lt_exp[i]);
    end

    // r0 suppression
    ret_hold = retired;
    drive(1, 1, 0, 5'd0, 32'hDEAD_BEEF, 32'd0, 3'd0, 0, 0);
    cycle();
    check("r0_no_write", {31'd0, Reg_write}, 32'd0);
    check("r0_retired", retired, ret_hold + 32'd1);

    // Stall for 3 cycles after a write to r7
    pulses = 0;
    drive(1, 1, 0, 5'd7, 32'hA5A5_0007, 32'd0, 3'd0, 0, 0);
    cycle();
    if (Reg_write === 1'b1) pulses++;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 5'd9, 32'h0BAD_0000 + i, 32'd0, 3'd0, 1, 0);
      cycle();
      if (Reg_write === 1'b1) pulses++;
      check("stall_hold_data", write_data, 32'hA5A5_0007);
    end
    check("stall_pulses", pulses, 32'd1);

    // Flush + stall together: bubble, no retire
    ret_hold = retired;
    drive(1, 1, 0, 5'd11, 32'h1111_1111, 32'd0, 3'd0, 1, 1);
    cycle();
    check("flush_stall_rw", {31'd0, Reg_write}, 32'd0);
    check("flush_stall_retired", retired, ret_hold);

    // Stall release loads the next input rather than replaying r7
    drive(1, 1, 0, 5'd3, 32'h3333_3333, 32'd0, 3'd0, 0, 0);
    cycle();
    check("release_reg", {27'd0, write_register}, 32'd3);

    // Async reset between edges while Reg_write is high
    drive(1, 1, 0, 5'd4, 32'h4444_4444, 32'd0, 3'd0, 0, 0);
    cycle();
    check("pre_reset_rw", {31'd0, Reg_write}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b0;

    // Retired counter wrap from a forced all-ones value
    drive(0, 0, 0, 5'd0, 32'd0, 32'd0, 3'd0, 0, 0);
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    m_ret = 32'hFFFF_FFFF;
    drive(1, 1, 0, 5'd6, 32'h6666_6666, 32'd0, 3'd0, 0, 0);
    cycle();
    check("retired_wrap", retired, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
            5'($urandom_range(0, 7)), $urandom, $urandom, 3'($urandom_range(0, 7)),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

MEM/WB pipeline register and write-back driver for the 5-stage pipeline: the writer side of `register_bank`. Latches MEM-stage results, performs load byte/halfword alignment and extension, and drives `write_register`/`write_data`/`Reg_write` into the register bank. It also holds the most recent committed write for one extra cycle so ID can bypass the bank's registered-read staleness, and counts retired instructions.

## Interface
- `DATA_W`, 32, datapath width.
- `REG_AW`, 5, register index width.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `stall` in 1: hold the MEM/WB latch.
- `flush` in 1: insert a bubble in place of the current MEM result.
- `valid_in` in 1: MEM stage holds a real instruction.
- `reg_write_in` in 1: instruction writes a register.
- `mem_to_reg` in 1: 1 = load data, 0 = ALU result.
- `rd_in` in REG_AW: destination register.
- `alu_result` in DATA_W: ALU result; bits [1:0] are the load byte offset.
- `mem_rdata` in DATA_W: data-memory read word.
- `load_type` in 3: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; 101–111 treated as lw.
- `write_register` out REG_AW: to the register bank.
- `write_data` out DATA_W: to the register bank.
- `Reg_write` out 1: to the register bank.
- `fwd_valid` out 1: `fwd_reg`/`fwd_data` hold the write committed at the previous edge.
- `fwd_reg` out REG_AW: register index of that write.
- `fwd_data` out DATA_W: data of that write.
- `retired` out 32: count of valid instructions accepted.

## Operation
- Capture at a rising edge:
  - `flush`=1 (priority over `stall`): latch becomes a bubble. `Reg_write` goes to 0; `write_register` and `write_data` hold their values.
  - else `stall`=0: latch loads.
    - `Reg_write` <= `valid_in & reg_write_in & (rd_in != 0)`.
    - `write_register` <= `rd_in`.
    - `write_data` <= `mem_to_reg` ? extended load : `alu_result`.
  - else (`stall`=1 only): `write_register` and `write_data` hold; `Reg_write` <= 0, so each instruction produces exactly one write pulse.
- Load extension is big-endian; byte 0 is [31:24].
  - lb/lbu: select byte by offset[1:0], then sign- or zero-extend.
  - lh/lhu: select half by offset[1] (offset[0] ignored; no alignment trap), then sign- or zero-extend.
  - lw: ignore the offset.
- Writes to r0 are never issued.
- Bypass hold, on every edge: `fwd_valid` <= `Reg_write`, `fwd_reg` <= `write_register`, `fwd_data` <= `write_data`.
- `retired` increments on any edge that loads a `valid_in`=1 instruction with `flush`=0 and `stall`=0. It wraps from 0xFFFFFFFF to 0.

## Timing
- Latency: MEM inputs appear on the bank-write outputs 1 cycle later. The bank commits at the following edge; `fwd_*` reflects that commit for the cycle after it.
- Reset (async, immediate): every output is 0, including `Reg_write`, `fwd_valid` and `retired`.
- Reset released mid-stream: the first edge after release captures normally. No write issues while `rst`=1.
- Simultaneous `flush`+`stall`: flush wins and a bubble is produced.
- Back-to-back writes to the same rd: each produces its own pulse. `fwd_*` tracks the latest.
- Stall longer than 1 cycle: outputs frozen and `Reg_write`=0 throughout. Releasing the stall loads the next input and does not replay the held instruction.
- No combinational path from any input to any output.

## Structure
- Shared package `pipeline_defs`:
  - load-type encodings `LT_LW`, `LT_LB`, `LT_LBU`, `LT_LH`, `LT_LHU`;
  - `DATA_W`/`REG_AW` defaults.
- Sub-module `load_extender`: combinational. Takes `mem_rdata`, `offset[1:0]`, `load_type` and returns the extended word. It is reusable by a later unaligned-load unit.

## Test plan
- Reset/basic write: hold `rst`=1, check all outputs 0. Release, present rd=5, ALU=0x1234_5678, reg_write=1 → next cycle `Reg_write`=1, reg=5, data=0x12345678. Following cycle `fwd_valid`=1, `fwd_reg`=5.
- Load extension: `mem_rdata`=0x80FF_7F01.
  - lb offset 0 → 0xFFFF_FF80; lbu offset 1 → 0x0000_00FF; lb offset 2 → 0x0000_007F.
  - lh offset 2 → 0x0000_7F01; lh offset 0 → 0xFFFF_80FF; lhu offset 0 → 0x0000_80FF.
  - lw → 0x80FF_7F01.
- r0 suppression: rd=0, reg_write=1, ALU=0xDEAD_BEEF → `Reg_write` stays 0 and `retired` increments.
- Stall/flush: stall for 3 cycles after a write to r7 → single `Reg_write` pulse, data held. Assert `flush`+`stall` together → bubble, `retired` unchanged.
- Async reset mid-operation: assert `rst` between edges while `Reg_write`=1 → outputs 0 immediately, before the next edge.
- Counter wrap: preload via 2^32 accepted instructions (or a forced value 0xFFFF_FFFF) plus one valid accept → `retired`=0.
